// File: rtl/npu_result_pkg.sv
// Shared register map, control/status bit positions and word-packing helpers
// for the NPU result collector.
package npu_result_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_FRAME  = 2'd3;

    localparam int CTRL_FLUSH    = 0;
    localparam int CTRL_CLR_OVF  = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_CLR_DONE = 3;

    localparam int ST_DONE  = 31;
    localparam int ST_OVF   = 30;
    localparam int ST_FULL  = 29;
    localparam int ST_EMPTY = 28;

    localparam int DATA_VLD = 31;

    function automatic logic [31:0] status_word(
        input logic        done,
        input logic        ovf,
        input logic        full,
        input logic        empty,
        input logic [15:0] cnt
    );
        logic [31:0] w;
        w           = {16'b0, cnt};
        w[ST_DONE]  = done;
        w[ST_OVF]   = ovf;
        w[ST_FULL]  = full;
        w[ST_EMPTY] = empty;
        return w;
    endfunction

endpackage

// File: rtl/npu_result_fifo.sv
// Synchronous FIFO; head is visible combinationally, push/pop/flush act at the clock edge.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle; flush wins over both.
module npu_result_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     push_ok,
    output logic                     pop_ok
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     head_ptr;
    logic [AW-1:0]     tail_ptr;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & ~flush & (~full | pop_ok);
    assign head    = mem[head_ptr];

    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem[tail_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push_ok) begin
                tail_ptr <= tail_ptr + AW'(1);
            end
            if (pop_ok) begin
                head_ptr <= head_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/npu_result_collector.sv
// Captures the NPU result stream into a FIFO behind an Avalon-MM slave (read latency 1) with frame-done irq.
// The NPU cannot be stalled: bytes arriving while full are dropped and flagged in a sticky overflow bit.
module npu_result_collector
    import npu_result_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d_in,
    input  logic              d_valid,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [1:0]        address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              push_ok;
    logic              pop_ok;

    logic              overflow;
    logic              done;
    logic              irq_en;
    logic [LEN_W-1:0]  frame_len;
    logic [LEN_W-1:0]  captured;
    logic [LEN_W-1:0]  cap_next;

    logic              rd_sel;
    logic              ctrl_wr;
    logic              frame_wr;
    logic              pop;
    logic              flush;
    logic              clr_done;
    logic              drop;
    logic [31:0]       rd_word;
    logic              unused_wd;

    assign rd_sel   = chipselect & read;
    assign ctrl_wr  = chipselect & write & (address == ADDR_CTRL);
    assign frame_wr = chipselect & write & (address == ADDR_FRAME);
    assign pop      = rd_sel & (address == ADDR_DATA);
    assign flush    = ctrl_wr & writedata[CTRL_FLUSH];
    assign clr_done = (ctrl_wr & writedata[CTRL_CLR_DONE]) | frame_wr;
    assign drop     = d_valid & ~flush & ~push_ok;
    assign cap_next = (&captured) ? captured : captured + LEN_W'(1);
    assign unused_wd = ^writedata[31:LEN_W];

    npu_result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (d_valid),
        .pop     (pop),
        .flush   (flush),
        .wdata   (d_in),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .push_ok (push_ok),
        .pop_ok  (pop_ok)
    );

    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA: begin
                if (pop_ok) begin
                    rd_word           = 32'(head);
                    rd_word[DATA_VLD] = 1'b1;
                end
            end
            ADDR_STATUS: rd_word = status_word(done, overflow, full, empty, 16'(count));
            ADDR_CTRL:   rd_word[CTRL_IRQ_EN] = irq_en;
            ADDR_FRAME:  rd_word = 32'(captured);
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow  <= 1'b0;
            done      <= 1'b0;
            irq_en    <= 1'b0;
            frame_len <= '0;
            captured  <= '0;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            if (rd_sel) begin
                readdata <= rd_word;
            end
            irq <= done & irq_en;
            if (ctrl_wr) begin
                irq_en <= writedata[CTRL_IRQ_EN];
            end
            if (frame_wr) begin
                frame_len <= writedata[LEN_W-1:0];
            end
            // A drop in the same cycle as a clear still leaves the flag set.
            if (ctrl_wr && writedata[CTRL_CLR_OVF]) begin
                overflow <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (clr_done) begin
                captured <= '0;
                done     <= 1'b0;
            end else if (push_ok) begin
                captured <= cap_next;
                if (frame_len != '0 && cap_next == frame_len) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
